// File: rtl/module_digit_capture_pkg.sv
// Shared keypad constants, entry FSM state encoding and width helper for the
// digit-capture block.
package pkg_keypad;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {ST_ENTRY, ST_CONVERT, ST_DONE} state_t;

  // Width needed to hold a digit count in 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/module_digit_capture_bcd_serial_conv.sv
// Serial BCD-to-binary converter: one x10-and-add step per cycle, most
// significant digit first, N_DIGITS steps after start.
module module_bcd_serial_conv #(
  parameter int N_DIGITS = 3,
  parameter int BIN_W    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]      acc,
  output logic                  done
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [IW-1:0] idx;
  logic          run;
  logic [3:0]    digit;

  assign digit = bcd[idx*4 +: 4];
  // High during the cycle whose closing edge applies the last digit.
  assign done  = run && (idx == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
      run <= 1'b0;
    end else if (start) begin
      acc <= '0;
      idx <= IW'(N_DIGITS - 1);
      run <= 1'b1;
    end else if (run) begin
      acc <= (acc << 3) + (acc << 1) + BIN_W'(digit);
      idx <= idx - 1'b1;
      if (idx == '0) run <= 1'b0;
    end
  end
endmodule

// File: rtl/module_digit_capture.sv
// Keypad decimal entry: BCD shift register with backspace/clear/enter, and on
// enter a serial BCD-to-binary conversion producing one result strobe.
module module_digit_capture
  import pkg_keypad::*;
#(
  parameter int N_DIGITS = 3,
  parameter int BIN_W    = 10,
  localparam int CW      = count_w(N_DIGITS),
  localparam int DW      = 4 * N_DIGITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_pulse,
  input  logic [3:0]       key_code,
  output logic [DW-1:0]    digits_bcd,
  output logic [CW-1:0]    digit_count,
  output logic             busy,
  output logic [BIN_W-1:0] result_bin,
  output logic             result_valid,
  output logic             key_err
);
  state_t           state, state_nxt;
  logic [DW-1:0]    bcd_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [BIN_W-1:0] res_nxt, acc;
  logic             err_nxt, rv_nxt, start, conv_done;

  module_bcd_serial_conv #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bcd   (digits_bcd),
    .acc   (acc),
    .done  (conv_done)
  );

  assign busy = (state == ST_CONVERT);

  always_comb begin
    state_nxt = state;
    bcd_nxt   = digits_bcd;
    cnt_nxt   = digit_count;
    res_nxt   = result_bin;
    err_nxt   = 1'b0;
    rv_nxt    = 1'b0;
    start     = 1'b0;
    case (state)
      ST_ENTRY: if (key_pulse) begin
        if (key_code <= 4'd9) begin
          if (digit_count < CW'(N_DIGITS)) begin
            bcd_nxt = (digits_bcd << 4) | DW'(key_code);
            cnt_nxt = digit_count + CW'(1);
          end else err_nxt = 1'b1;
        end else begin
          case (key_code)
            KEY_BACK: if (digit_count != '0) begin
              bcd_nxt = digits_bcd >> 4;
              cnt_nxt = digit_count - CW'(1);
            end else err_nxt = 1'b1;
            KEY_CLEAR: begin
              bcd_nxt = '0;
              cnt_nxt = '0;
            end
            KEY_ENTER: if (digit_count != '0) begin
              state_nxt = ST_CONVERT;
              start     = 1'b1;
            end else err_nxt = 1'b1;
            default: ;  // D/E/F ignored silently
          endcase
        end
      end
      ST_CONVERT: begin
        err_nxt = key_pulse;
        if (conv_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        err_nxt   = key_pulse;
        res_nxt   = acc;
        rv_nxt    = 1'b1;
        bcd_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = ST_ENTRY;
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_ENTRY;
      digits_bcd   <= '0;
      digit_count  <= '0;
      result_bin   <= '0;
      result_valid <= 1'b0;
      key_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      digits_bcd   <= bcd_nxt;
      digit_count  <= cnt_nxt;
      result_bin   <= res_nxt;
      result_valid <= rv_nxt;
      key_err      <= err_nxt;
    end
  end
endmodule

// File: tb/tb_module_digit_capture.sv
// Directed bench for module_digit_capture; expected conversion results are
// queued when enter is pressed and checked when result_valid strobes.
module tb_module_digit_capture;
  localparam int N = 3;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          reset, key_pulse;
  logic [3:0]    key_code;
  logic [4*N-1:0] digits_bcd;
  logic [1:0]    digit_count;
  logic          busy, result_valid, key_err;
  logic [BW-1:0] result_bin;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  module_digit_capture #(.N_DIGITS(N), .BIN_W(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_pulse    (key_pulse),
    .key_code     (key_code),
    .digits_bcd   (digits_bcd),
    .digit_count  (digit_count),
    .busy         (busy),
    .result_bin   (result_bin),
    .result_valid (result_valid),
    .key_err      (key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result_valid", 1, 0);
      else chk("result_bin", int'(result_bin), exp_q.pop_front());
    end
  end

  // Called at a falling edge; key is sampled on the next rising edge and the
  // task returns at the falling edge after it.
  task automatic press(input logic [3:0] code);
    key_pulse = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_pulse = 1'b0;
  endtask

  // lat0 = cycles already elapsed since the enter edge.
  task automatic run_conv(input int lat0, input int exp_busy);
    int lat = lat0;
    int bc  = 0;
    while (!result_valid && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    chk("result_latency", lat, N + 1);
    chk("busy_cycles", bc, exp_busy);
    chk("bcd_after_done", int'(digits_bcd), 0);
    chk("count_after_done", int'(digit_count), 0);
    @(negedge clk);
    chk("result_valid_one_cycle", int'(result_valid), 0);
  endtask

  initial begin
    reset = 1'b1; key_pulse = 1'b1; key_code = 4'h1;
    repeat (3) @(negedge clk);
    chk("rst_bcd", int'(digits_bcd), 0);
    chk("rst_count", int'(digit_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result_bin), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_err", int'(key_err), 0);
    reset = 1'b0; key_pulse = 1'b0;
    @(negedge clk);

    // 1,2,3,A -> 123
    press(4'h1); press(4'h2); press(4'h3);
    chk("bcd_123", int'(digits_bcd), 'h123);
    chk("count_3", int'(digit_count), 3);
    exp_q.push_back(123);
    press(4'hA);
    run_conv(0, 3);

    // fourth digit rejected
    press(4'h9); press(4'h9); press(4'h9); press(4'h7);
    chk("full_err", int'(key_err), 1);
    chk("bcd_999", int'(digits_bcd), 'h999);
    @(negedge clk);
    chk("full_err_pulse", int'(key_err), 0);
    exp_q.push_back(999);
    press(4'hA);
    run_conv(0, 3);

    // backspace
    press(4'h4); press(4'h5);
    chk("bcd_45", int'(digits_bcd), 'h45);
    press(4'hB);
    chk("bcd_4", int'(digits_bcd), 'h4);
    chk("count_1", int'(digit_count), 1);
    chk("back_no_err", int'(key_err), 0);
    press(4'h6);
    chk("bcd_46", int'(digits_bcd), 'h46);
    exp_q.push_back(46);
    press(4'hA);
    run_conv(0, 3);
    press(4'hB);
    chk("back_empty_err", int'(key_err), 1);

    // D ignored, clear, enter on empty
    press(4'hD);
    chk("ignore_no_err", int'(key_err), 0);
    chk("ignore_count", int'(digit_count), 0);
    press(4'h7); press(4'hC);
    chk("clear_count", int'(digit_count), 0);
    chk("clear_bcd", int'(digits_bcd), 0);
    chk("clear_no_err", int'(key_err), 0);
    press(4'hA);
    chk("enter_empty_err", int'(key_err), 1);
    chk("enter_empty_busy", int'(busy), 0);
    chk("result_held", int'(result_bin), 46);

    // key while busy
    press(4'h8);
    exp_q.push_back(8);
    press(4'hA);
    press(4'h2);
    chk("busy_key_err", int'(key_err), 1);
    chk("busy_bcd_untouched", int'(digits_bcd), 'h8);
    run_conv(1, 2);

    // reset mid-conversion
    press(4'h5);
    press(4'hA);
    @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort_result", int'(result_bin), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_bcd", int'(digits_bcd), 0);
    repeat (6) @(negedge clk);
    chk("abort_no_valid", int'(result_valid), 0);

    // back in ENTRY and working
    press(4'h4); press(4'h2);
    exp_q.push_back(42);
    press(4'hA);
    run_conv(0, 3);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
